// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, forwarding select encodings and the hazard
// tracking entry used by the pipeline hazard scoreboard.
package mips_pkg;

   localparam int unsigned MIPS_REG_W = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_SRA = 6'h03;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_OR  = 6'h25;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [MIPS_REG_W-1:0] dest;
      logic                  is_load;
      logic [MIPS_REG_W-1:0] rs;
      logic                  use_rs;
      logic [MIPS_REG_W-1:0] rt;
      logic                  use_rt;
   } hz_entry_t;

   // Destination 0 is never a real write, so it can never source a forward.
   // A load still sitting in MEM has no result yet; the load-use stall covers it.
   function automatic logic [1:0] fwd_sel(
      input logic                  use_src,
      input logic [MIPS_REG_W-1:0] src,
      input hz_entry_t             mem,
      input hz_entry_t             wb
   );
      logic [1:0] sel;
      sel = FWD_REG;
      if (use_src && mem.valid && !mem.is_load &&
          (mem.dest != {MIPS_REG_W{1'b0}}) && (mem.dest == src)) begin
         sel = FWD_MEM;
      end else if (use_src && wb.valid &&
                   (wb.dest != {MIPS_REG_W{1'b0}}) && (wb.dest == src)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Source-operand usage and load detection for the instruction in ID.
module hazard_src_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic       use_rs,
   output logic       use_rt,
   output logic       is_load
);

   // Classify which register fields the instruction actually reads
   always_comb begin
      use_rs  = 1'b1;
      use_rt  = 1'b0;
      is_load = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            use_rt = 1'b1;
            case (funct)
               FN_SLL, FN_SRL, FN_SRA: use_rs = 1'b0;
               default:                use_rs = 1'b1;
            endcase
         end
         OP_LUI, OP_J: begin
            use_rs = 1'b0;
         end
         OP_SW, OP_BEQ, OP_BNE: begin
            use_rt = 1'b1;
         end
         OP_LW: begin
            is_load = 1'b1;
         end
         default: begin
            use_rs = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use stall plus EX operand forwarding selects.
// Optional stall-cycle statistics counter enabled with HAZARD_STATS_EN.
module hazard_scoreboard
   import mips_pkg::*;
#(
   parameter int REG_ADDR_W = MIPS_REG_W,
   parameter int STAT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_instr,
   input  logic              i_id_valid,
   input  logic              i_we_rd,
   input  logic              i_we_rt,
   input  logic              i_hold,
   input  logic              i_flush,
   output logic              o_stall,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic [STAT_W-1:0] o_stall_count
);

   logic [REG_ADDR_W-1:0] rs_s;
   logic [REG_ADDR_W-1:0] rt_s;
   logic [REG_ADDR_W-1:0] rd_s;
   logic [REG_ADDR_W-1:0] dest_s;
   logic                  use_rs_s;
   logic                  use_rt_s;
   logic                  is_load_s;
   logic                  stall_s;
   hz_entry_t             id_entry_s;
   hz_entry_t             ex_r;
   hz_entry_t             mem_r;
   hz_entry_t             wb_r;
   logic                  unused_s;

   assign rs_s = i_instr[25:21];
   assign rt_s = i_instr[20:16];
   assign rd_s = i_instr[15:11];

   // Shift amount and the WB operand fields are carried only for entry symmetry
   assign unused_s = ^{i_instr[10:6], wb_r.is_load, wb_r.rs, wb_r.use_rs,
                       wb_r.rt, wb_r.use_rt};

   hazard_src_decode u_src_decode (
      .opcode  (i_instr[31:26]),
      .funct   (i_instr[5:0]),
      .use_rs  (use_rs_s),
      .use_rt  (use_rt_s),
      .is_load (is_load_s)
   );

   // Destination select from the decoder's write enables
   always_comb begin
      dest_s = {REG_ADDR_W{1'b0}};
      if (i_we_rd) begin
         dest_s = rd_s;
      end else if (i_we_rt) begin
         dest_s = rt_s;
      end else begin
         dest_s = {REG_ADDR_W{1'b0}};
      end
   end

   // Assemble the entry that would enter EX this cycle
   always_comb begin
      id_entry_s         = '0;
      id_entry_s.valid   = 1'b1;
      id_entry_s.dest    = dest_s;
      id_entry_s.is_load = is_load_s;
      id_entry_s.rs      = rs_s;
      id_entry_s.use_rs  = use_rs_s;
      id_entry_s.rt      = rt_s;
      id_entry_s.use_rt  = use_rt_s;
   end

   // Load-use detection against the load currently in EX; flush overrides it
   always_comb begin
      stall_s = 1'b0;
      if (i_id_valid && !i_flush && ex_r.valid && ex_r.is_load &&
          (ex_r.dest != {REG_ADDR_W{1'b0}})) begin
         stall_s = (use_rs_s && (rs_s == ex_r.dest)) ||
                   (use_rt_s && (rt_s == ex_r.dest));
      end else begin
         stall_s = 1'b0;
      end
   end

   // Stage shadow registers; hold freezes everything, a stall or flush injects a bubble
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ex_r  <= '0;
         mem_r <= '0;
         wb_r  <= '0;
      end else if (!i_hold) begin
         if (i_id_valid && !i_flush && !stall_s) begin
            ex_r <= id_entry_s;
         end else begin
            ex_r <= '0;
         end
         mem_r <= ex_r;
         wb_r  <= mem_r;
      end else begin
         ex_r  <= ex_r;
         mem_r <= mem_r;
         wb_r  <= wb_r;
      end
   end

   assign o_stall = stall_s;
   assign o_fwd_a = fwd_sel(ex_r.valid & ex_r.use_rs, ex_r.rs, mem_r, wb_r);
   assign o_fwd_b = fwd_sel(ex_r.valid & ex_r.use_rt, ex_r.rt, mem_r, wb_r);

`ifdef HAZARD_STATS_EN
   logic [STAT_W-1:0] stall_count_r;

   // Saturating count of cycles where a stall actually took effect
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stall_count_r <= {STAT_W{1'b0}};
      end else if (stall_s && !i_hold && !(&stall_count_r)) begin
         stall_count_r <= stall_count_r + {{(STAT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign o_stall_count = stall_count_r;
`else
   assign o_stall_count = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (forwarding, load-use,
// flush, hold, reset and the optional stall counter).
module tb_hazard_scoreboard;

   localparam int STAT_W = 16;

`ifdef HAZARD_STATS_EN
   localparam int EXP_CNT4 = 4;
   localparam int EXP_CNT5 = 5;
`else
   localparam int EXP_CNT4 = 0;
   localparam int EXP_CNT5 = 0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       instr;
   logic              id_valid;
   logic              we_rd;
   logic              we_rt;
   logic              hold;
   logic              flush;
   logic              stall;
   logic [1:0]        fwd_a;
   logic [1:0]        fwd_b;
   logic [STAT_W-1:0] stall_count;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_ADDR_W(5), .STAT_W(STAT_W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_instr       (instr),
      .i_id_valid    (id_valid),
      .i_we_rd       (we_rd),
      .i_we_rt       (we_rt),
      .i_hold        (hold),
      .i_flush       (flush),
      .o_stall       (stall),
      .o_fwd_a       (fwd_a),
      .o_fwd_b       (fwd_b),
      .o_stall_count (stall_count)
   );

   function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic wrd, input logic wrt,
                        input logic fl);
      instr    = ins;
      id_valid = 1'b1;
      we_rd    = wrd;
      we_rt    = wrt;
      flush    = fl;
      #1;
   endtask

   task automatic idle();
      instr    = 32'h0000_0000;
      id_valid = 1'b0;
      we_rd    = 1'b0;
      we_rt    = 1'b0;
      flush    = 1'b0;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         idle();
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      hold = 1'b0;
      idle();
      tick();
      tick();
      rst = 1'b0;
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_fwd_a", 32'(fwd_a), 32'd0);
      chk("reset_fwd_b", 32'(fwd_b), 32'd0);
      chk("reset_count", 32'(stall_count), 32'd0);

      // ADD $3,$1,$2 ; SUB $4,$3,$5 -> MEM forward on rs
      issue(r_op(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0);
      tick();
      issue(r_op(5'd3, 5'd5, 5'd4, 6'h22), 1'b1, 1'b0, 1'b0);
      chk("b2b_no_stall", 32'(stall), 32'd0);
      tick();
      idle();
      chk("b2b_fwd_a_mem", 32'(fwd_a), 32'd1);
      chk("b2b_fwd_b_reg", 32'(fwd_b), 32'd0);
      drain();

      // ADD $3,$1,$2 ; NOP ; OR $6,$7,$3 -> WB forward on rt
      issue(r_op(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      tick();
      issue(r_op(5'd7, 5'd3, 5'd6, 6'h25), 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      chk("gap_fwd_a_reg", 32'(fwd_a), 32'd0);
      chk("gap_fwd_b_wb", 32'(fwd_b), 32'd2);
      drain();

      // ADD $3 ; ADD $3 ; SUB $4,$3,$3 -> youngest (MEM) wins on both operands
      issue(r_op(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0);
      tick();
      issue(r_op(5'd4, 5'd5, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0);
      tick();
      issue(r_op(5'd3, 5'd3, 5'd4, 6'h22), 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      chk("prio_fwd_a_mem", 32'(fwd_a), 32'd1);
      chk("prio_fwd_b_mem", 32'(fwd_b), 32'd1);
      drain();

      // LW $8,0($1) ; ADD $9,$8,$2 -> one stall cycle, then WB forward
      issue(i_op(6'h23, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b0);
      chk("lw_issue_no_stall", 32'(stall), 32'd0);
      tick();
      issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b0);
      chk("lu_stall", 32'(stall), 32'd1);
      tick();
      chk("lu_stall_cleared", 32'(stall), 32'd0);
      chk("lu_bubble_fwd_a", 32'(fwd_a), 32'd0);
      tick();
      idle();
      chk("lu_fwd_a_wb", 32'(fwd_a), 32'd2);
      chk("lu_fwd_b_reg", 32'(fwd_b), 32'd0);
      drain();

      // ADDI $0,$1,5 ; ADD $2,$0,$0 -> register 0 never tracked
      issue(i_op(6'h08, 5'd1, 5'd0, 16'h0005), 1'b0, 1'b1, 1'b0);
      tick();
      issue(r_op(5'd0, 5'd0, 5'd2, 6'h20), 1'b1, 1'b0, 1'b0);
      chk("r0_no_stall", 32'(stall), 32'd0);
      tick();
      idle();
      chk("r0_fwd_a", 32'(fwd_a), 32'd0);
      chk("r0_fwd_b", 32'(fwd_b), 32'd0);
      drain();

      // LW $8 ; dependent ADD flushed -> flush beats load-use
      issue(i_op(6'h23, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b0);
      tick();
      issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b1);
      chk("flush_lu_no_stall", 32'(stall), 32'd0);
      tick();
      issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b0);
      chk("flush_ex_bubble_no_stall", 32'(stall), 32'd0);
      drain();

      // Flushed ALU consumer must not reach EX
      issue(r_op(5'd1, 5'd2, 5'd3, 6'h20), 1'b1, 1'b0, 1'b0);
      tick();
      issue(r_op(5'd3, 5'd5, 5'd4, 6'h22), 1'b1, 1'b0, 1'b1);
      tick();
      idle();
      chk("flush_ex_bubble_fwd_a", 32'(fwd_a), 32'd0);
      drain();

      // Fresh counter: five load-use pairs, the last one held for 3 cycles
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int p = 0; p < 4; p++) begin
         issue(i_op(6'h23, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b0);
         tick();
         issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b0);
         tick();
         tick();
      end
      issue(i_op(6'h23, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b0);
      tick();
      issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b0);
      hold = 1'b1;
      #1;
      for (int h = 0; h < 3; h++) begin
         tick();
      end
      chk("hold_stall_kept", 32'(stall), 32'd1);
      chk("hold_count_frozen", 32'(stall_count), 32'(EXP_CNT4));
      hold = 1'b0;
      #1;
      tick();
      chk("post_hold_no_stall", 32'(stall), 32'd0);
      tick();
      idle();
      chk("count_five", 32'(stall_count), 32'(EXP_CNT5));
      drain();

      // Reset in the middle of a stall
      issue(i_op(6'h23, 5'd1, 5'd8, 16'h0000), 1'b0, 1'b1, 1'b0);
      tick();
      issue(r_op(5'd8, 5'd2, 5'd9, 6'h20), 1'b1, 1'b0, 1'b0);
      chk("pre_rst_stall", 32'(stall), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_count_clear", 32'(stall_count), 32'd0);
      idle();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard unit sitting directly downstream of the destination decoder in the ID stage.
- Consumes the ID instruction and its rd/rt write enables.
- Tracks in-flight destination registers through the EX, MEM and WB stage shadow registers.
- Drives the load-use stall/bubble and the EX-stage operand forwarding selects.

Parameters:
REG_ADDR_W, 5, register index width
STAT_W, 16, stall counter width (used only with HAZARD_STATS_EN)

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_instr  input  32  instruction currently in ID
i_id_valid  input  1  ID instruction valid
i_we_rd  input  1  ID instr writes rd (from destination decoder)
i_we_rt  input  1  ID instr writes rt (from destination decoder)
i_hold  input  1  global freeze (cache miss etc.)
i_flush  input  1  kill ID instruction (taken branch/jump)
o_stall  output  1  hold PC and IF/ID; a bubble is inserted into EX
o_fwd_a  output  2  EX rs operand select: 00 regfile, 01 MEM result, 10 WB result
o_fwd_b  output  2  EX rt operand select, same encoding
o_stall_count  output  STAT_W  saturating stall-cycle count (0 without macro)

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-high, on i_rst. On reset, EX/MEM/WB entries are invalid, the counter is 0, and every output is 0.
- ID decode (combinational):
  - rs field = instr[25:21], rt = [20:16], rd = [15:11].
  - dest = rd if i_we_rd, rt if i_we_rt, none otherwise.
  - dest index 0 counts as no write.
  - is_load = opcode 100011.
  - use_rs: all opcodes except LUI, J, and R-type SLL/SRL/SRA.
  - use_rt: opcode 0, SW, BEQ, BNE.
- Entry format: {valid, dest, is_load, rs, use_rs, rt, use_rt}.
- Load-use stall: o_stall = i_id_valid & ~i_flush & EX.valid & EX.is_load & ((use_rs & rs==EX.dest) | (use_rt & rt==EX.dest)).
  - Purely combinational from current inputs and EX entry.
  - Lasts exactly 1 cycle per load-use pair, because the bubble clears it.
- Stage advance on posedge, when ~i_hold and ~i_rst:
  - EX <= ID entry if i_id_valid & ~i_flush & ~o_stall; otherwise an invalid bubble.
  - MEM <= EX; WB <= MEM.
- i_hold=1 freezes all entries and the counter. o_stall is still computed.
- Forwarding (combinational from registered entries, for the instruction in EX):
  - o_fwd_a = 01 if EX.use_rs & MEM.valid & MEM.dest==EX.rs.
  - Else 10 if the same test against WB matches.
  - Else 00.
  - o_fwd_b is the same using rt/use_rt.
  - MEM has priority over WB.
  - MEM entries that are loads are never forwarded from MEM. The stall guarantees they are not needed.
- The register file is write-through, so no ID-stage bypass is required. The WB stage compare exists only for the EX operands.
- Simultaneous i_flush and load-use: flush wins, o_stall=0, bubble inserted.
- Simultaneous i_hold and i_flush: nothing moves. The flush must be re-asserted by its source after the hold.
- Reset mid-stall: next cycle all entries are invalid and o_stall=0.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: o_stall_count increments on each cycle with o_stall & ~i_hold. It saturates at all-ones and is cleared by i_rst.
- Undefined: the counter logic is absent and o_stall_count is tied to 0. The port list is unchanged.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (LW, SW, BEQ, BNE, J, LUI, ADDI...) and funct constants (SLL, SRL, SRA...).
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - entry struct typedef.
- One natural sub-module: hazard_src_decode, a combinational use_rs/use_rt/is_load decoder from i_instr.
- Stage registers and compare logic stay in the top.

Test Plan:
- ADD $3,$1,$2 then SUB $4,$3,$5 back-to-back -> no stall; when SUB is in EX, o_fwd_a=01, o_fwd_b=00.
- ADD $3,$1,$2; NOP; OR $6,$7,$3 -> when OR is in EX, o_fwd_b=10, o_fwd_a=00.
- LW $8,0($1) then ADD $9,$8,$2 -> o_stall=1 for exactly 1 cycle; bubble in EX; then ADD in EX with o_fwd_a=10.
- ADDI $0,$1,5 then ADD $2,$0,$0 -> no stall, o_fwd_a=o_fwd_b=00 (reg 0 never tracked).
- LW $8 followed by a dependent ADD with i_flush=1 in the same cycle -> o_stall=0; EX bubble next cycle.
- Five load-use pairs, then i_hold for 3 cycles during a stall, then reset -> with HAZARD_STATS_EN o_stall_count=5 before reset (hold cycles not counted), 0 after; without the macro it is always 0.
